// File: rtl/preadd_mult_acc.sv
// Pipelined pre-adder multiply-accumulate: (a +/- b) * c, optionally accumulated
// into a wide P register with saturating or wrapping overflow.
module preadd_mult_acc #(
   parameter int SIZEIN   = 8,
   parameter int ACCW     = 2*SIZEIN+8,
   parameter int SATURATE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ce,
   input  logic                     in_valid,
   input  logic                     sub,
   input  logic                     acc_en,
   input  logic                     acc_clr,
   input  logic signed [SIZEIN-1:0] a,
   input  logic signed [SIZEIN-1:0] b,
   input  logic signed [SIZEIN-1:0] c,
   output logic                     out_valid,
   output logic signed [ACCW-1:0]   out_data,
   output logic                     ovf
);

   localparam int MW = 2*SIZEIN+1;

   // S1
   logic              v1, sub1, en1, clr1;
   logic [SIZEIN-1:0] a1, b1, c1;
   // S2
   logic              v2, en2, clr2;
   logic [SIZEIN:0]   d2;
   logic [SIZEIN-1:0] c2;
   // S3
   logic              v3, en3, clr3;
   logic [MW-1:0]     m3;

   logic [SIZEIN:0]        a_x, b_x, d_next;
   logic signed [MW-1:0]   d_w, c_w, m_next;
   logic [ACCW:0]          m_ext, sum;
   logic [ACCW-1:0]        p_next;
   logic                   ovf_next, over;

   always_comb begin
      a_x    = {a1[SIZEIN-1], a1};
      b_x    = {b1[SIZEIN-1], b1};
      d_next = sub1 ? (a_x - b_x) : (a_x + b_x);
   end

   // Both multiplier operands are widened to the full product width, so the
   // truncated product is exact.
   always_comb begin
      d_w    = {{SIZEIN{d2[SIZEIN]}}, d2};
      c_w    = {{(SIZEIN+1){c2[SIZEIN-1]}}, c2};
      m_next = d_w * c_w;
   end

   always_comb begin
      m_ext    = {{(ACCW+1-MW){m3[MW-1]}}, m3};
      sum      = {out_data[ACCW-1], out_data} + m_ext;
      over     = sum[ACCW] ^ sum[ACCW-1];
      p_next   = sum[ACCW-1:0];
      ovf_next = 1'b0;
      if (!en3 || clr3) begin
         p_next = m_ext[ACCW-1:0];
      end else if (over) begin
         ovf_next = 1'b1;
         if (SATURATE != 0) begin
            p_next = sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1 <= 1'b0; sub1 <= 1'b0; en1 <= 1'b0; clr1 <= 1'b0;
         a1 <= '0;   b1 <= '0;     c1 <= '0;
         v2 <= 1'b0; en2 <= 1'b0;  clr2 <= 1'b0;
         d2 <= '0;   c2 <= '0;
         v3 <= 1'b0; en3 <= 1'b0;  clr3 <= 1'b0;
         m3 <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         ovf       <= 1'b0;
      end else if (ce) begin
         v1 <= in_valid; sub1 <= sub; en1 <= acc_en; clr1 <= acc_clr;
         a1 <= a;        b1 <= b;     c1 <= c;

         v2 <= v1; en2 <= en1; clr2 <= clr1;
         d2 <= d_next; c2 <= c1;

         v3 <= v2; en3 <= en2; clr3 <= clr2;
         m3 <= m_next;

         out_valid <= v3;
         if (v3) begin
            out_data <= p_next;
            ovf      <= ovf_next;
         end
      end
   end

endmodule
